// File: rtl/imem_loader.sv
// Purpose : boot loader; assembles a length/word/checksum byte stream into imem writes and holds the core in reset until a good load.
// Latency : one imem write one cycle after the 4th byte of each word is accepted; flags update on the accepting edge.
// Backpr. : in_ready is high only in LEN_LO/LEN_HI/DATA/CSUM; an upstream stall of any length just pauses the FSM.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   start             one-cycle request to begin a load (honoured in IDLE/DONE/ERR only)
//   in_valid/in_ready byte stream handshake, in_data is the byte
//   imem_we/addr/wdata instruction memory write port (one strobe per word)
//   core_rst          1 holds the core in reset
//   busy/done/err     load status; words_loaded counts words written this load
module imem_loader #(
    parameter int IMEM_DEPTH = 1024,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(IMEM_DEPTH);

    state_t             state_q, state_d;
    logic [15:0]        len_q, len_d;
    logic [1:0]         bidx_q, bidx_d;
    logic [7:0]         csum_q, csum_d;
    logic [23:0]        asm_q, asm_d;       // bytes 0..2 of the word in flight

    logic               in_ready_d;
    logic               imem_we_d;
    logic [ADDR_W-1:0]  imem_addr_d;
    logic [31:0]        imem_wdata_d;
    logic               core_rst_d;
    logic               busy_d;
    logic               done_d;
    logic               err_d;
    logic [15:0]        words_loaded_d;

    logic               xfer;
    logic [15:0]        new_len;
    logic [15:0]        words_inc;

    // in_ready is a registered copy of "this state accepts bytes", so the
    // handshake seen by upstream is exactly what the FSM acts on.
    assign xfer      = in_valid & in_ready;
    assign new_len   = {in_data, len_q[7:0]};
    assign words_inc = words_loaded + 16'd1;

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        bidx_d         = bidx_q;
        csum_d         = csum_q;
        asm_d          = asm_q;
        in_ready_d     = in_ready;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr;
        imem_wdata_d   = imem_wdata;
        core_rst_d     = core_rst;
        busy_d         = busy;
        done_d         = done;
        err_d          = err;
        words_loaded_d = words_loaded;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d        = S_LEN_LO;
                    in_ready_d     = 1'b1;
                    busy_d         = 1'b1;
                    core_rst_d     = 1'b1;
                    done_d         = 1'b0;
                    err_d          = 1'b0;
                    words_loaded_d = 16'd0;
                    csum_d         = 8'd0;
                    bidx_d         = 2'd0;
                    len_d          = 16'd0;
                end
            end

            S_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN_HI;
                end
            end

            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    if ({1'b0, new_len} > DEPTH_L) begin
                        state_d    = S_ERR;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        err_d      = 1'b1;
                        core_rst_d = 1'b1;
                    end else if (new_len == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (xfer) begin
                    csum_d = csum_q ^ in_data;
                    bidx_d = bidx_q + 2'd1;
                    case (bidx_q)
                        2'd0: asm_d[7:0]   = in_data;
                        2'd1: asm_d[15:8]  = in_data;
                        2'd2: asm_d[23:16] = in_data;
                        default: begin
                            // Word complete: the write is a pipeline register,
                            // so byte acceptance never pauses for it.
                            imem_we_d      = 1'b1;
                            imem_addr_d    = words_loaded[ADDR_W-1:0];
                            imem_wdata_d   = {in_data, asm_q};
                            words_loaded_d = words_inc;
                            if (words_inc == len_q) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end

            S_CSUM: begin
                if (xfer) begin
                    in_ready_d = 1'b0;
                    busy_d     = 1'b0;
                    if (in_data == csum_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
                    end else begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        core_rst_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            len_q        <= 16'd0;
            bidx_q       <= 2'd0;
            csum_q       <= 8'd0;
            asm_q        <= 24'd0;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            core_rst     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            bidx_q       <= bidx_d;
            csum_q       <= csum_d;
            asm_q        <= asm_d;
            in_ready     <= in_ready_d;
            imem_we      <= imem_we_d;
            imem_addr    <= imem_addr_d;
            imem_wdata   <= imem_wdata_d;
            core_rst     <= core_rst_d;
            busy         <= busy_d;
            done         <= done_d;
            err          <= err_d;
            words_loaded <= words_loaded_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Purpose : exercises imem_loader with good, bad, empty, oversize, stalled and reset-interrupted loads.
// Latency : write expectations are queued when the 4th byte of a word is driven and retired at each imem_we.
// Backpr. : bytes are held on in_valid until the loader shows in_ready, with optional idle gaps.
module tb_imem_loader;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       words_loaded;

    imem_loader #(.IMEM_DEPTH(1024), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    int          wr_count;
    logic        early_release;
    logic [41:0] exp_q[$];          // {addr, data}
    logic [7:0]  stream[$];
    logic [31:0] mem [0:1023];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Retire one expected write per strobe and mirror it into a shadow memory.
    always @(negedge clk) begin
        if (rst && imem_we) begin
            logic [41:0] e;
            wr_count++;
            mem[imem_addr] = imem_wdata;
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 32'(wr_count), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("we_addr", 32'(imem_addr), 32'(e[41:32]));
                chk("we_data", imem_wdata, e[31:0]);
            end
        end
    end

    // The core may only leave reset together with a successful completion.
    always @(negedge clk) begin
        if (rst && !core_rst && !done) early_release = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                accepted = 1'b1;
            end
        end
        in_valid = 1'b0;
        chk("byte_accept", 32'(accepted), 32'd1);
    endtask

    // Drive stream[] (after a start pulse); queue each word's write as its last byte is driven.
    task automatic run_stream(input int max_gap, input int start_at, input int stop_after);
        int len;
        len = 0;
        if (stream.size() >= 2) len = {stream[1], stream[0]};
        pulse_start();
        for (int i = 0; i < stream.size() && i < stop_after; i++) begin
            int gap;
            gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
            if (i == start_at) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            for (int g = 0; g < gap; g++) tick();
            if (i >= 2 && i < 2 + 4 * len && ((i - 2) % 4) == 3) begin
                logic [9:0]  a;
                logic [31:0] w;
                a = 10'((i - 2) / 4);
                w = {stream[i], stream[i-1], stream[i-2], stream[i-3]};
                exp_q.push_back({a, w});
            end
            send_byte(stream[i]);
        end
    endtask

    task automatic new_test();
        wr_count      = 0;
        early_release = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 1024; k++) mem[k] = 32'hDEAD_BEEF;
    endtask

    task automatic check_final(input string tag, input logic e_done, input logic e_err,
                               input logic e_core_rst, input int e_words, input int e_writes);
        for (int c = 0; c < 3; c++) tick();
        @(negedge clk);
        chk({tag, "_done"},     32'(done),         32'(e_done));
        chk({tag, "_err"},      32'(err),          32'(e_err));
        chk({tag, "_core_rst"}, 32'(core_rst),     32'(e_core_rst));
        chk({tag, "_busy"},     32'(busy),         32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready),     32'd0);
        chk({tag, "_words"},    32'(words_loaded), 32'(e_words));
        chk({tag, "_writes"},   32'(wr_count),     32'(e_writes));
        chk({tag, "_pending"},  32'(exp_q.size()), 32'd0);
        chk({tag, "_early"},    32'(early_release), 32'd0);
        tick();
    endtask

    task automatic load_good_stream();
        stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00,
                   8'h13, 8'h01, 8'h30, 8'h00, 8'h91};
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready),     32'd0);
        chk({tag, "_we"},       32'(imem_we),      32'd0);
        chk({tag, "_addr"},     32'(imem_addr),    32'd0);
        chk({tag, "_wdata"},    imem_wdata,        32'd0);
        chk({tag, "_core_rst"}, 32'(core_rst),     32'd1);
        chk({tag, "_busy"},     32'(busy),         32'd0);
        chk({tag, "_done"},     32'(done),         32'd0);
        chk({tag, "_err"},      32'(err),          32'd0);
        chk({tag, "_words"},    32'(words_loaded), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        new_test();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b1;
        tick();

        // 1: two-word load
        new_test();
        load_good_stream();
        run_stream(0, -1, 1000);
        check_final("t1", 1'b1, 1'b0, 1'b0, 2, 2);
        chk("t1_mem0", mem[0], 32'h0020_0093);
        chk("t1_mem1", mem[1], 32'h0030_0113);

        // 2: bad checksum
        new_test();
        load_good_stream();
        stream[10] = 8'h90;
        run_stream(0, -1, 1000);
        check_final("t2", 1'b0, 1'b1, 1'b1, 2, 2);

        // 3: empty program
        new_test();
        stream = '{8'h00, 8'h00, 8'h00};
        run_stream(0, -1, 1000);
        check_final("t3", 1'b1, 1'b0, 1'b0, 0, 0);

        // 4: oversize length; bytes offered afterwards must not be taken
        new_test();
        stream = '{8'h01, 8'h04};
        run_stream(0, -1, 1000);
        chk("t4_ready_after_len", 32'(in_ready), 32'd0);
        chk("t4_err_after_len",   32'(err),      32'd1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int c = 0; c < 4; c++) tick();
        in_valid = 1'b0;
        check_final("t4", 1'b0, 1'b1, 1'b1, 0, 0);

        // 5: random stalls plus a start pulse in the middle of the data
        new_test();
        load_good_stream();
        run_stream(5, 6, 1000);
        check_final("t5", 1'b1, 1'b0, 1'b0, 2, 2);
        chk("t5_mem0", mem[0], 32'h0020_0093);
        chk("t5_mem1", mem[1], 32'h0030_0113);

        // 6: reset after 5 data bytes, then a clean rerun
        new_test();
        load_good_stream();
        run_stream(0, -1, 7);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("t6_rst");
        chk("t6_writes_before_rst", 32'(wr_count), 32'd1);
        chk("t6_pending", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        new_test();
        load_good_stream();
        run_stream(2, -1, 1000);
        check_final("t6", 1'b1, 1'b0, 1'b0, 2, 2);
        chk("t6_mem0", mem[0], 32'h0020_0093);
        chk("t6_mem1", mem[1], 32'h0030_0113);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
